fix_session_engine: RTL and testbench
=====================================

Name: fix_session_engine

Overview:
- Byte-serial FIX session-layer engine. Initiator role only.
- Sits between a host byte link and the session peer (acceptor).
- Sends Logon on start, parses incoming messages byte by byte, and emits session-level replies (Heartbeat, Logout) as a byte stream with a valid strobe.
- Wire format is ASCII. Every message begins with "35=<type>" and ends with ';' (0x3B).

Parameters:
- HB_DEFAULT, 64: heartbeat idle interval in clk cycles, used when the configured interval is 0.
- MAX_MSG_LEN, 255: maximum number of bytes in one received message, terminator included.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  din carries a valid received byte this cycle.
- start  in  1  one-cycle pulse that opens a session (Logon).
- configure  in  1  one-cycle pulse that latches configuration from din.
- din  in  8  received byte, or configuration value when configure=1.
- dout  out  8  transmitted byte.
- valid  out  1  dout holds a transmitted byte this cycle.

Behaviour:
- Reset (reset sampled high at a rising clk edge; clock is clk):
  - dout=0x00, valid=0, session=IDLE, configured=0, parser=P_3, pending=NONE, hb counter=0.
- Configure:
  - configure=1 sets configured=1 and latches hb_int=din.
  - hb_int=0 selects HB_DEFAULT.
  - Ignored while the transmitter is busy.
- Session FSM states: IDLE, LOGON_SENT, ACTIVE.
  - IDLE + start + configured: queue Logon, go LOGON_SENT.
  - start before configure, or outside IDLE: ignored.
  - LOGON_SENT + received 'A': go ACTIVE.
  - LOGON_SENT + received '5': queue Logout, go IDLE.
  - LOGON_SENT + other types: ignored.
  - ACTIVE + received '1' (TestRequest): queue Heartbeat.
  - ACTIVE + received '0': restart hb counter only.
  - ACTIVE + received '5': queue Logout, go IDLE.
  - ACTIVE + other valid types: no output.
- Parser (advances only on cycles with enable=1):
  - P_3 expects '3'; P_5 expects '5'; P_EQ expects '='; P_TYPE captures the type byte; P_BODY skips bytes until ';'.
  - Mismatch in P_3..P_EQ: mark the message invalid and skip to ';'.
  - ';' received anywhere: completes the message and returns the parser to P_3.
  - Valid message: its type is acted on in the cycle after ';' is sampled.
  - Byte count exceeding MAX_MSG_LEN: marks the message invalid.
- Transmit templates (5 bytes each):
  - Logon: 33 35 3D 41 3B.
  - Heartbeat: 33 35 3D 30 3B.
  - Logout: 33 35 3D 35 3B.
- Transmit timing:
  - First byte with valid=1 appears on the cycle after the triggering start or ';' is sampled.
  - Remaining bytes follow on consecutive cycles. No gaps, no backpressure.
  - Between messages: valid=0, dout holds its last value.
- Pending register (one deep):
  - A request made while transmitting is stored.
  - Logout overwrites Heartbeat. A new Heartbeat does not overwrite Logout.
  - The stored request transmits on the cycle after the current terminator.
- Reception continues during transmission.
- Reset mid-message aborts transmission at once: valid=0 on the next cycle.
- enable and start in the same cycle: both are processed.

Optional Feature:
- HEARTBEAT_TIMER_EN defined:
  - In ACTIVE, the hb counter counts cycles with no enable and no transmission.
  - On reaching the interval (hb_int or HB_DEFAULT), queue Heartbeat and clear the counter.
  - Any received byte or any transmission clears the counter.
- Not defined: no counter; Heartbeat is sent only in reply to TestRequest.

Test Plan:
- Reset, configure with din=0x00, start → valid high for 5 consecutive cycles starting 1 cycle after start, dout=33,35,3D,41,3B.
- Logon done, then feed "35=A;" then "35=1;" → state ACTIVE after 'A'; after the second ';', dout=33,35,3D,30,3B.
- start with no prior configure → valid stays 0 for 100 cycles.
- ACTIVE, feed "35=5;" → dout=33,35,3D,35,3B, state IDLE; a subsequent "35=1;" gives no output.
- Malformed "36=1;", then "35=1;" → no output for the first message, Heartbeat for the second.
- HEARTBEAT_TIMER_EN, configure din=0x10, ACTIVE idle → Heartbeat every 16 idle cycles (+5 transmit cycles); without the macro, no output.

Source files
------------

// File: rtl/fix_session_engine.sv
// fix_session_engine: byte-serial FIX session layer (initiator role only).
// Define HEARTBEAT_TIMER_EN to add the idle-interval Heartbeat generator.
module fix_session_engine #(
  parameter int HB_DEFAULT  = 64,
  parameter int MAX_MSG_LEN = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       configure,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       valid
);

  localparam int CNTW = $clog2(MAX_MSG_LEN + 1);
  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_MSG_LEN);

  localparam logic [7:0] CH_3    = 8'h33;
  localparam logic [7:0] CH_5    = 8'h35;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] CH_A    = 8'h41;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_1    = 8'h31;

  typedef enum logic [1:0] {IDLE, LOGON_SENT, ACTIVE} sess_t;
  typedef enum logic [2:0] {P_3, P_5, P_EQ, P_TYPE, P_BODY} parse_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_LOGON, REQ_HB, REQ_LOGOUT} req_t;

  function automatic logic [7:0] tmpl_byte(req_t kind, logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0: b = CH_3;
      3'd1: b = CH_5;
      3'd2: b = CH_EQ;
      3'd3: begin
        case (kind)
          REQ_LOGON:  b = CH_A;
          REQ_LOGOUT: b = CH_5;
          default:    b = CH_0;
        endcase
      end
      default: b = CH_SEMI;
    endcase
    return b;
  endfunction

  // A held Logout/Logon is never displaced by a later Heartbeat.
  function automatic req_t merge_req(req_t held, req_t incoming);
    if (incoming == REQ_NONE) return held;
    if (incoming == REQ_HB && held != REQ_NONE) return held;
    return incoming;
  endfunction

  sess_t            state, state_nxt;
  parse_t           pstate, pstate_nxt;
  logic             msg_bad, msg_bad_nxt;
  logic [7:0]       msg_type, msg_type_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;
  logic             msg_done;
  logic             configured;
  logic             hb_fire;
  req_t             new_req;
  req_t             pending, pending_nxt;
  req_t             tx_kind, tx_kind_nxt;
  logic [2:0]       tx_idx, tx_idx_nxt;
  logic [7:0]       dout_nxt;
  logic             valid_nxt;

  // Parser: cnt counts bytes before ';' and saturates at MAX_CNT.
  always_comb begin
    pstate_nxt   = pstate;
    msg_bad_nxt  = msg_bad;
    msg_type_nxt = msg_type;
    cnt_nxt      = cnt;
    msg_done     = 1'b0;
    if (enable) begin
      if (din == CH_SEMI) begin
        msg_done    = (pstate == P_BODY) && !msg_bad && (cnt < MAX_CNT);
        pstate_nxt  = P_3;
        msg_bad_nxt = 1'b0;
        cnt_nxt     = '0;
      end else begin
        if (cnt < MAX_CNT) cnt_nxt = cnt + 1'b1;
        case (pstate)
          P_3: begin
            if (din == CH_3) pstate_nxt = P_5;
            else begin msg_bad_nxt = 1'b1; pstate_nxt = P_BODY; end
          end
          P_5: begin
            if (din == CH_5) pstate_nxt = P_EQ;
            else begin msg_bad_nxt = 1'b1; pstate_nxt = P_BODY; end
          end
          P_EQ: begin
            if (din == CH_EQ) pstate_nxt = P_TYPE;
            else begin msg_bad_nxt = 1'b1; pstate_nxt = P_BODY; end
          end
          P_TYPE: begin
            msg_type_nxt = din;
            pstate_nxt   = P_BODY;
          end
          default: pstate_nxt = P_BODY;
        endcase
      end
    end
  end

  // A received Heartbeat ('0') needs no branch: every received byte clears the timer.
  always_comb begin
    state_nxt = state;
    new_req   = REQ_NONE;
    case (state)
      IDLE: begin
        if (start && configured) begin
          new_req   = REQ_LOGON;
          state_nxt = LOGON_SENT;
        end
      end
      LOGON_SENT: begin
        if (msg_done) begin
          if (msg_type == CH_A) state_nxt = ACTIVE;
          else if (msg_type == CH_5) begin
            new_req   = REQ_LOGOUT;
            state_nxt = IDLE;
          end
        end
      end
      ACTIVE: begin
        if (msg_done) begin
          if (msg_type == CH_1) new_req = REQ_HB;
          else if (msg_type == CH_5) begin
            new_req   = REQ_LOGOUT;
            state_nxt = IDLE;
          end
        end else if (hb_fire) begin
          new_req = REQ_HB;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt   = valid;
    dout_nxt    = dout;
    tx_idx_nxt  = tx_idx;
    tx_kind_nxt = tx_kind;
    pending_nxt = pending;
    if (valid && tx_idx != 3'd4) begin
      tx_idx_nxt  = tx_idx + 3'd1;
      dout_nxt    = tmpl_byte(tx_kind, tx_idx + 3'd1);
      pending_nxt = merge_req(pending, new_req);
    end else if (pending != REQ_NONE) begin
      valid_nxt   = 1'b1;
      tx_kind_nxt = pending;
      tx_idx_nxt  = '0;
      dout_nxt    = tmpl_byte(pending, 3'd0);
      pending_nxt = new_req;
    end else if (new_req != REQ_NONE) begin
      valid_nxt   = 1'b1;
      tx_kind_nxt = new_req;
      tx_idx_nxt  = '0;
      dout_nxt    = tmpl_byte(new_req, 3'd0);
    end else begin
      valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pstate     <= P_3;
      msg_bad    <= 1'b0;
      msg_type   <= '0;
      cnt        <= '0;
      pending    <= REQ_NONE;
      tx_kind    <= REQ_NONE;
      tx_idx     <= '0;
      dout       <= '0;
      valid      <= 1'b0;
      configured <= 1'b0;
    end else begin
      state    <= state_nxt;
      pstate   <= pstate_nxt;
      msg_bad  <= msg_bad_nxt;
      msg_type <= msg_type_nxt;
      cnt      <= cnt_nxt;
      pending  <= pending_nxt;
      tx_kind  <= tx_kind_nxt;
      tx_idx   <= tx_idx_nxt;
      dout     <= dout_nxt;
      valid    <= valid_nxt;
      if (configure && !valid) configured <= 1'b1;
    end
  end

`ifdef HEARTBEAT_TIMER_EN
  logic [7:0]  hb_int;
  logic [15:0] hb_cnt;
  logic [15:0] hb_interval;

  assign hb_interval = (hb_int == '0) ? 16'(HB_DEFAULT) : {8'h00, hb_int};
  assign hb_fire     = (state == ACTIVE) && !enable && !valid
                       && (hb_cnt == hb_interval - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hb_int <= '0;
      hb_cnt <= '0;
    end else begin
      if (configure && !valid) hb_int <= din;
      if (state != ACTIVE || enable || valid || hb_fire) hb_cnt <= '0;
      else hb_cnt <= hb_cnt + 16'd1;
    end
  end
`else
  assign hb_fire = 1'b0;
`endif

endmodule

// File: tb/tb_fix_session_engine.sv
// Directed, table-driven bench for fix_session_engine, plus hand sequences for
// the message-length boundary, the heartbeat timer and start-before-configure.
module tb_fix_session_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       configure = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       rst;
    logic       cfg;
    logic       st;
    logic       en;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] hbb[5];

  fix_session_engine #(.HB_DEFAULT(64), .MAX_MSG_LEN(255)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .configure(configure), .din(din), .dout(dout), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, valid=%0b dout=%02h", valid, dout);
    $fatal(1);
  end

  function void r(input logic rs, input logic cf, input logic s, input logic e,
                  input logic [7:0] d, input logic ev, input logic [7:0] ed);
    tbl.push_back('{rs, cf, s, e, d, ev, ed});
  endfunction

  function void quiet(input string s, input logic [7:0] hold);
    for (int i = 0; i < s.len(); i++) r(0, 0, 0, 1, s[i], 0, hold);
  endfunction

  function void idle(input int n, input logic [7:0] hold);
    for (int i = 0; i < n; i++) r(0, 0, 0, 0, 8'h00, 0, hold);
  endfunction

  function void tail(input logic [7:0] t);
    r(0, 0, 0, 0, 8'h00, 1, 8'h35);
    r(0, 0, 0, 0, 8'h00, 1, 8'h3D);
    r(0, 0, 0, 0, 8'h00, 1, t);
    r(0, 0, 0, 0, 8'h00, 1, 8'h3B);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [8:0] got,
                     input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: valid/dout=%0b/%02h, expected %0b/%02h",
               name, idx, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  task automatic feed_long(input int n_fill, input logic accept, input string tag);
    string hdr;
    hdr = "35=1";
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; din = hdr[i]; tick();
      chk(tag, i, {valid, dout}, {1'b0, 8'h3B});
    end
    for (int i = 0; i < n_fill; i++) begin
      enable = 1'b1; din = 8'h78; tick();
      chk(tag, 4 + i, {valid, dout}, {1'b0, 8'h3B});
    end
    enable = 1'b1; din = 8'h3B; tick();
    enable = 1'b0;
    chk(tag, 1000, {valid, dout}, accept ? {1'b1, 8'h33} : {1'b0, 8'h3B});
    for (int i = 1; i < 6; i++) begin
      tick();
      chk(tag, 1000 + i, {valid, dout},
          (accept && i < 5) ? {1'b1, hbb[i]} : {1'b0, 8'h3B});
    end
  endtask

  initial begin
    hbb = '{8'h33, 8'h35, 8'h3D, 8'h30, 8'h3B};

    r(1, 0, 0, 0, 8'h00, 0, 8'h00);
    r(0, 1, 0, 0, 8'h00, 0, 8'h00);
    r(0, 0, 1, 0, 8'h00, 1, 8'h33);
    tail(8'h41); idle(1, 8'h3B);
    quiet("35=A;", 8'h3B);
    quiet("35=1", 8'h3B); r(0, 0, 0, 1, 8'h3B, 1, 8'h33);
    // second TestRequest received while the first reply is on the wire
    r(0, 0, 0, 1, 8'h33, 1, 8'h35);
    r(0, 0, 0, 1, 8'h35, 1, 8'h3D);
    r(0, 0, 0, 1, 8'h3D, 1, 8'h30);
    r(0, 0, 0, 1, 8'h31, 1, 8'h3B);
    r(0, 0, 0, 1, 8'h3B, 1, 8'h33);
    tail(8'h30); idle(1, 8'h3B);
    quiet("36=1;", 8'h3B); quiet("35=X;", 8'h3B); quiet("35=;", 8'h3B);
    quiet("35=1", 8'h3B); r(0, 0, 0, 1, 8'h3B, 1, 8'h33); tail(8'h30); idle(1, 8'h3B);
    quiet("35=5", 8'h3B); r(0, 0, 0, 1, 8'h3B, 1, 8'h33); tail(8'h35); idle(1, 8'h3B);
    quiet("35=1;", 8'h3B);
    // start with a received byte; a Logout arrives mid-Logon and is held
    r(0, 0, 1, 1, 8'h33, 1, 8'h33);
    r(0, 0, 0, 1, 8'h35, 1, 8'h35);
    r(0, 0, 0, 1, 8'h3D, 1, 8'h3D);
    r(0, 0, 0, 1, 8'h35, 1, 8'h41);
    r(0, 0, 0, 1, 8'h3B, 1, 8'h3B);
    r(0, 0, 0, 0, 8'h00, 1, 8'h33); tail(8'h35); idle(1, 8'h3B);
    // reset during Logon, then start is ignored until reconfigured
    r(0, 0, 1, 0, 8'h00, 1, 8'h33);
    r(0, 0, 0, 0, 8'h00, 1, 8'h35);
    r(1, 0, 0, 0, 8'h00, 0, 8'h00);
    r(0, 0, 1, 0, 8'h00, 0, 8'h00);
    idle(1, 8'h00);
    r(0, 1, 0, 0, 8'h00, 0, 8'h00);
    r(0, 0, 1, 0, 8'h00, 1, 8'h33); tail(8'h41); idle(1, 8'h3B);
    quiet("35=1;", 8'h3B);
    quiet("35=A;", 8'h3B);
    quiet("35=1", 8'h3B); r(0, 0, 0, 1, 8'h3B, 1, 8'h33); tail(8'h30); idle(1, 8'h3B);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; configure = tbl[i].cfg; start = tbl[i].st;
      enable = tbl[i].en; din = tbl[i].d;
      tick();
      chk("vec", i, {valid, dout}, {tbl[i].ev, tbl[i].ed});
    end
    reset = 1'b0; configure = 1'b0; start = 1'b0; enable = 1'b0; din = 8'h00;

    feed_long(250, 1'b1, "maxlen_ok");
    feed_long(251, 1'b0, "maxlen_over");

    configure = 1'b1; din = 8'h10; tick(); configure = 1'b0;
    chk("hb_cfg", 0, {valid, dout}, {1'b0, 8'h3B});
    begin
      string hb0;
      hb0 = "35=0;";
      for (int i = 0; i < 5; i++) begin
        enable = 1'b1; din = hb0[i]; tick();
        chk("hb_rx", i, {valid, dout}, {1'b0, 8'h3B});
      end
      enable = 1'b0;
    end
    for (int t = 1; t <= 60; t++) begin
      logic       ev;
      logic [7:0] ed;
      ev = 1'b0; ed = 8'h3B;
`ifdef HEARTBEAT_TIMER_EN
      if (t >= 16 && ((t - 16) % 21) < 5) begin
        ev = 1'b1; ed = hbb[(t - 16) % 21];
      end
`endif
      tick();
      chk("hb_timer", t, {valid, dout}, {ev, ed});
    end

    reset = 1'b1; tick(); reset = 1'b0;
    chk("noconf_reset", 0, {valid, dout}, {1'b0, 8'h00});
    start = 1'b1; tick(); start = 1'b0;
    chk("noconf_start", 0, {valid, dout}, {1'b0, 8'h00});
    for (int i = 1; i < 100; i++) begin
      tick();
      chk("noconf_idle", i, {valid, dout}, {1'b0, 8'h00});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
